// File: rtl/mp_pkg.sv
// Shared multiplier-host definitions: multiplier state codes, host FSM encoding, default timeout.
// Used by mp_host_ctrl and mp_host_timer.
package mp_pkg;

  localparam logic [1:0] MP_IDLE = 2'b00;
  localparam logic [1:0] MP_EXEC = 2'b01;
  localparam logic [1:0] MP_DONE = 2'b10;

  typedef logic [2:0] host_state_t;

  localparam host_state_t H_IDLE   = 3'd0;
  localparam host_state_t H_START  = 3'd1;
  localparam host_state_t H_WAIT   = 3'd2;
  localparam host_state_t H_RESULT = 3'd3;
  localparam host_state_t H_CLEAR  = 3'd4;

  localparam int DEFAULT_TIMEOUT = 64;

endpackage

// File: rtl/mp_host_timer.sv
// H_WAIT watchdog: 8-bit count cleared on wait entry; expired is combinational from the count (0 cycles).
// No backpressure; saturates at 255 so it never wraps back below the threshold.
module mp_host_timer #(
  parameter int TIMEOUT = mp_pkg::DEFAULT_TIMEOUT
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear,
  input  logic en,
  output logic expired
);

  localparam logic [7:0] LAST = 8'(TIMEOUT - 1);

  logic [7:0] cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (en && cnt != 8'hFF) begin
      cnt <= cnt + 8'd1;
    end
  end

  assign expired = en && (cnt == LAST);

endmodule

// File: rtl/mp_host_ctrl.sv
// Host sequencer for an external multiplier; 3 cycles accept-to-res_valid plus EXEC time, registered outputs.
// Holds the result until res_ready; cmd_ready low while busy. MP_HOST_TIMEOUT_EN adds an H_WAIT watchdog.
module mp_host_ctrl
  import mp_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [WIDTH-1:0]     cmd_a,
  input  logic [WIDTH-1:0]     cmd_b,
  input  logic                 abort,
  output logic [WIDTH-1:0]     mp_multiplicand,
  output logic [WIDTH-1:0]     mp_multiplier,
  output logic                 mp_op_start,
  output logic                 mp_interrupt,
  output logic                 mp_op_clear,
  input  logic [1:0]           mp_state,
  input  logic [2*WIDTH-1:0]   mp_result,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic [2*WIDTH-1:0]   res_data,
  output logic                 res_err
);

  host_state_t state;
  logic        tmo_hit;

`ifdef MP_HOST_TIMEOUT_EN
  mp_host_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (state == H_START),
    .en      (state == H_WAIT),
    .expired (tmo_hit)
  );
`else
  logic unused_timeout;
  assign unused_timeout = ^8'(TIMEOUT);
  assign tmo_hit        = 1'b0;
`endif

  // Pulse outputs default low each cycle; a state sets them for exactly one cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state           <= H_IDLE;
      cmd_ready       <= 1'b1;
      mp_multiplicand <= '0;
      mp_multiplier   <= '0;
      mp_op_start     <= 1'b0;
      mp_interrupt    <= 1'b0;
      mp_op_clear     <= 1'b0;
      res_valid       <= 1'b0;
      res_data        <= '0;
      res_err         <= 1'b0;
    end else begin
      mp_op_start  <= 1'b0;
      mp_interrupt <= 1'b0;
      mp_op_clear  <= 1'b0;
      case (state)
        H_IDLE: begin
          if (cmd_valid && cmd_ready) begin
            mp_multiplicand <= cmd_a;
            mp_multiplier   <= cmd_b;
            cmd_ready       <= 1'b0;
            mp_op_start     <= 1'b1;
            state           <= H_START;
          end
        end
        H_START: state <= H_WAIT;
        H_WAIT: begin
          // A finished product always beats a simultaneous abort or timeout.
          if (mp_state == MP_DONE) begin
            res_data  <= mp_result;
            res_err   <= 1'b0;
            res_valid <= 1'b1;
            state     <= H_RESULT;
          end else if (abort || tmo_hit) begin
            mp_interrupt <= 1'b1;
            res_data     <= '0;
            res_err      <= 1'b1;
            res_valid    <= 1'b1;
            state        <= H_RESULT;
          end
        end
        H_RESULT: begin
          if (res_ready) begin
            res_valid   <= 1'b0;
            mp_op_clear <= 1'b1;
            state       <= H_CLEAR;
          end
        end
        H_CLEAR: begin
          cmd_ready <= 1'b1;
          state     <= H_IDLE;
        end
        default: begin
          cmd_ready <= 1'b1;
          state     <= H_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mp_host_ctrl.sv
// Directed bench for mp_host_ctrl: normal, backpressure, abort, collision, abort-ignore, reset, optional timeout.
// Inputs driven and outputs sampled on the falling clock edge.
module tb_mp_host_ctrl;
  import mp_pkg::*;

  localparam int W = 32;

  logic           clk = 1'b0;
  logic           reset_n;
  logic           cmd_valid;
  logic           cmd_ready;
  logic [W-1:0]   cmd_a;
  logic [W-1:0]   cmd_b;
  logic           abort;
  logic [W-1:0]   mp_multiplicand;
  logic [W-1:0]   mp_multiplier;
  logic           mp_op_start;
  logic           mp_interrupt;
  logic           mp_op_clear;
  logic [1:0]     mp_state;
  logic [2*W-1:0] mp_result;
  logic           res_valid;
  logic           res_ready;
  logic [2*W-1:0] res_data;
  logic           res_err;

  int checks = 0;
  int errors = 0;
  int start_cnt = 0;
  int int_cnt = 0;
  int clr_cnt = 0;

  mp_host_ctrl #(.WIDTH(W), .TIMEOUT(8)) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .cmd_valid       (cmd_valid),
    .cmd_ready       (cmd_ready),
    .cmd_a           (cmd_a),
    .cmd_b           (cmd_b),
    .abort           (abort),
    .mp_multiplicand (mp_multiplicand),
    .mp_multiplier   (mp_multiplier),
    .mp_op_start     (mp_op_start),
    .mp_interrupt    (mp_interrupt),
    .mp_op_clear     (mp_op_clear),
    .mp_state        (mp_state),
    .mp_result       (mp_result),
    .res_valid       (res_valid),
    .res_ready       (res_ready),
    .res_data        (res_data),
    .res_err         (res_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mp_op_start)  start_cnt <= start_cnt + 1;
    if (mp_interrupt) int_cnt   <= int_cnt + 1;
    if (mp_op_clear)  clr_cnt   <= clr_cnt + 1;
  end

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  // Presents a command, checks the accept and start pulse, leaves the FSM in its first H_WAIT cycle.
  task automatic start_cmd(input string tag, input logic [W-1:0] a, input logic [W-1:0] b);
    cmd_a     = a;
    cmd_b     = b;
    cmd_valid = 1'b1;
    check_val({tag, "_cmd_rdy"}, 64'(cmd_ready), 64'd1);
    step();
    cmd_valid = 1'b0;
    check_val({tag, "_op_start"}, 64'(mp_op_start), 64'd1);
    check_val({tag, "_busy"}, 64'(cmd_ready), 64'd0);
    check_val({tag, "_opa"}, 64'(mp_multiplicand), 64'(a));
    check_val({tag, "_opb"}, 64'(mp_multiplier), 64'(b));
    mp_state = MP_EXEC;
    step();
    check_val({tag, "_start_1cyc"}, 64'(mp_op_start), 64'd0);
  endtask

  // Accepts the result and walks through H_CLEAR back to H_IDLE.
  task automatic finish_cmd(input string tag);
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;
    check_val({tag, "_op_clear"}, 64'(mp_op_clear), 64'd1);
    check_val({tag, "_vld_drop"}, 64'(res_valid), 64'd0);
    mp_state = MP_IDLE;
    step();
    check_val({tag, "_clear_1cyc"}, 64'(mp_op_clear), 64'd0);
    check_val({tag, "_rdy_back"}, 64'(cmd_ready), 64'd1);
  endtask

  initial begin
    int s_start;
    int s_int;
    int s_clr;
    bit stable;

    reset_n   = 1'b0;
    cmd_valid = 1'b0;
    cmd_a     = '0;
    cmd_b     = '0;
    abort     = 1'b0;
    mp_state  = MP_IDLE;
    mp_result = '0;
    res_ready = 1'b0;
    repeat (2) step();
    check_val("rst_cmd_ready", 64'(cmd_ready), 64'd1);
    check_val("rst_res_valid", 64'(res_valid), 64'd0);
    check_val("rst_res_data", res_data, 64'd0);
    check_val("rst_pulses", {61'd0, mp_op_start, mp_interrupt, mp_op_clear}, 64'd0);
    reset_n = 1'b1;
    step();

    // Normal: 3*5, DONE in the 4th EXEC cycle.
    s_start = start_cnt; s_int = int_cnt; s_clr = clr_cnt;
    start_cmd("norm", 32'd3, 32'd5);
    repeat (2) step();
    check_val("norm_no_early_vld", 64'(res_valid), 64'd0);
    mp_state  = MP_DONE;
    mp_result = 64'd15;
    step();
    check_val("norm_vld", 64'(res_valid), 64'd1);
    check_val("norm_data", res_data, 64'd15);
    check_val("norm_err", 64'(res_err), 64'd0);
    finish_cmd("norm");
    check_val("norm_start_pulses", 64'(start_cnt - s_start), 64'd1);
    check_val("norm_clear_pulses", 64'(clr_cnt - s_clr), 64'd1);
    check_val("norm_no_int", 64'(int_cnt - s_int), 64'd0);

    // Backpressure, also the minimum-latency path (DONE in the first H_WAIT cycle).
    start_cmd("bp", 32'd7, 32'd9);
    mp_state  = MP_DONE;
    mp_result = 64'd63;
    step();
    check_val("bp_min_latency_vld", 64'(res_valid), 64'd1);
    stable = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      if (!(res_valid && res_data == 64'd63 && !res_err && !cmd_ready)) stable = 1'b0;
    end
    check_val("bp_hold", 64'(stable), 64'd1);
    finish_cmd("bp");

    // Abort on the second EXEC cycle in H_WAIT.
    s_int = int_cnt;
    start_cmd("abt", 32'd11, 32'd13);
    step();
    mp_result = 64'h1234;
    abort     = 1'b1;
    step();
    abort = 1'b0;
    check_val("abt_int", 64'(mp_interrupt), 64'd1);
    check_val("abt_vld", 64'(res_valid), 64'd1);
    check_val("abt_err", 64'(res_err), 64'd1);
    check_val("abt_data", res_data, 64'd0);
    mp_state = MP_IDLE;
    step();
    check_val("abt_int_1cyc", 64'(mp_interrupt), 64'd0);
    check_val("abt_int_pulses", 64'(int_cnt - s_int), 64'd1);
    finish_cmd("abt");

    // DONE and abort together: DONE wins.
    s_int = int_cnt;
    start_cmd("col", 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    mp_state  = MP_DONE;
    mp_result = 64'hFFFF_FFFE_0000_0001;
    abort     = 1'b1;
    step();
    abort = 1'b0;
    check_val("col_err", 64'(res_err), 64'd0);
    check_val("col_data", res_data, 64'hFFFF_FFFE_0000_0001);
    step();
    check_val("col_no_int", 64'(int_cnt - s_int), 64'd0);
    finish_cmd("col");

    // abort held through H_IDLE and H_START has no effect.
    s_int = int_cnt;
    abort = 1'b1;
    start_cmd("ign", 32'd2, 32'd3);
    abort = 1'b0;
    step();
    check_val("ign_still_wait", 64'(res_valid), 64'd0);
    check_val("ign_no_int", 64'(int_cnt - s_int), 64'd0);
    mp_state  = MP_DONE;
    mp_result = 64'd6;
    step();
    check_val("ign_data", res_data, 64'd6);
    check_val("ign_err", 64'(res_err), 64'd0);
    finish_cmd("ign");

    // Reset during H_WAIT, then a fresh command.
    s_int = int_cnt; s_clr = clr_cnt;
    start_cmd("rst", 32'd2, 32'd4);
    step();
    reset_n = 1'b0;
    #1;
    check_val("rstw_cmd_ready", 64'(cmd_ready), 64'd1);
    check_val("rstw_opa", 64'(mp_multiplicand), 64'd0);
    check_val("rstw_opb", 64'(mp_multiplier), 64'd0);
    check_val("rstw_res", {62'd0, res_valid, res_err}, 64'd0);
    mp_state = MP_IDLE;
    step();
    reset_n = 1'b1;
    step();
    check_val("rstw_no_clear", 64'(clr_cnt - s_clr), 64'd0);
    check_val("rstw_no_int", 64'(int_cnt - s_int), 64'd0);
    start_cmd("post", 32'd6, 32'd7);
    mp_state  = MP_DONE;
    mp_result = 64'd42;
    step();
    check_val("post_data", res_data, 64'd42);
    check_val("post_err", 64'(res_err), 64'd0);
    finish_cmd("post");

`ifdef MP_HOST_TIMEOUT_EN
    // No DONE: the watchdog fires in the 8th H_WAIT cycle.
    start_cmd("tmo", 32'd5, 32'd5);
    repeat (7) step();
    check_val("tmo_not_yet", {62'd0, mp_interrupt, res_valid}, 64'd0);
    step();
    check_val("tmo_int", 64'(mp_interrupt), 64'd1);
    check_val("tmo_err", 64'(res_err), 64'd1);
    check_val("tmo_data", res_data, 64'd0);
    finish_cmd("tmo");
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
